// File: rtl/mano_mem_responder.sv
// mano_mem_responder: 16-bit word memory with zero-latency CPU reads and a streaming loader.
// Optional CPU write protection below WP_LIMIT is built in when MANO_MEM_WP_EN is defined.
module mano_mem_responder #(
   parameter int unsigned ADDR_W   = 12,
   parameter logic [15:0] WP_LIMIT = 16'h0010
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [15:0]       cpu_addr,
   input  logic [15:0]       cpu_wdata,
   input  logic              cpu_we_n,
   output logic [15:0]       cpu_rdata,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic              load_valid,
   input  logic [15:0]       load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_busy,
   output logic              load_done,
   output logic [ADDR_W:0]   load_count,
   output logic              wp_err
);

   localparam int unsigned    DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

`ifdef MANO_MEM_WP_EN
   localparam bit WP_EN = 1'b1;
`else
   localparam bit WP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wp_err_q, wp_err_d;

   logic [15:0]       mem_q [DEPTH];

   logic [ADDR_W-1:0] cpu_a;
   logic              cpu_req;
   logic              wp_hit;
   logic              ld_we;
   logic              cpu_we;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [15:0]       mem_wd;
   logic              unused_addr_hi;

   assign cpu_a          = cpu_addr[ADDR_W-1:0];
   assign unused_addr_hi = ^cpu_addr[15:ADDR_W];
   assign cpu_req        = ~cpu_we_n;

   // Zone compare widened so WP_LIMIT above the address range still works.
   assign wp_hit = WP_EN && (32'(cpu_a) < 32'(WP_LIMIT));

   // Loader FSM
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ld_we   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (load_start) begin
               ptr_d   = load_base;
               cnt_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (load_valid) begin
               ld_we = 1'b1;
               ptr_d = ptr_q + 1'b1;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (load_last) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Loader owns the write port; a colliding CPU write is silently dropped.
   always_comb begin
      cpu_we   = cpu_req & ~ld_we & ~wp_hit;
      wp_err_d = cpu_req & ~ld_we & wp_hit;
      mem_we   = ld_we | cpu_we;
      mem_wa   = cpu_a;
      mem_wd   = cpu_wdata;
      if (ld_we) begin
         mem_wa = ptr_q;
         mem_wd = load_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         wp_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         wp_err_q <= wp_err_d;
      end
   end

   // Storage is deliberately outside reset so a loaded image survives it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_wa] <= mem_wd;
      end
   end

   assign cpu_rdata  = mem_q[cpu_a];
   assign load_ready = (state_q == S_LOAD);
   assign load_busy  = (state_q == S_LOAD);
   assign load_done  = (state_q == S_DONE);
   assign load_count = cnt_q;
   assign wp_err     = wp_err_q;

endmodule

// File: tb/tb_mano_mem_responder.sv
// Directed bench for mano_mem_responder: scoreboard of expected memory words,
// drained through the combinational CPU read port.
module tb_mano_mem_responder;

   logic        clk;
   logic        reset_n;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_we_n;
   logic [15:0] cpu_rdata;
   logic        load_start;
   logic [11:0] load_base;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic        load_busy;
   logic        load_done;
   logic [12:0] load_count;
   logic        wp_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] a;
      logic [15:0] d;
   } ent_t;

   ent_t sb[$];

   mano_mem_responder dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_we_n   (cpu_we_n),
      .cpu_rdata  (cpu_rdata),
      .load_start (load_start),
      .load_base  (load_base),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .load_busy  (load_busy),
      .load_done  (load_done),
      .load_count (load_count),
      .wp_err     (wp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [11:0] a, input logic [15:0] d);
      ent_t e;
      e.a = a;
      e.d = d;
      sb.push_back(e);
   endtask

   task automatic drain();
      ent_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cpu_addr = {4'h0, e.a};
         #1;
         chk($sformatf("mem_%03h", e.a), cpu_rdata, e.d);
      end
   endtask

   logic [15:0] lw [3];
   logic [15:0] prot_exp;

   initial begin
      lw[0] = 16'h7800;
      lw[1] = 16'h7400;
      lw[2] = 16'h7200;
      reset_n    = 1'b0;
      load_start = 1'b0;
      load_base  = '0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      cpu_addr   = '0;
      cpu_wdata  = '0;
      cpu_we_n   = 1'b1;

      #3;
      chk("rst_busy", load_busy, 0);
      chk("rst_ready", load_ready, 0);
      chk("rst_done", load_done, 0);
      chk("rst_wperr", wp_err, 0);
      chk("rst_count", load_count, 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Load test, with a stray load_start mid-stream that must be ignored
      load_start = 1'b1;
      load_base  = 12'h100;
      tick();
      load_start = 1'b0;
      chk("load_busy", load_busy, 1);
      chk("load_ready", load_ready, 1);
      chk("load_cnt0", load_count, 0);
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = lw[i];
         load_last  = (i == 2);
         if (i == 1) begin
            load_start = 1'b1;
            load_base  = 12'h555;
         end
         push(12'h100 + 12'(i), lw[i]);
         tick();
         load_start = 1'b0;
         if (i < 2) chk($sformatf("load_cnt%0d", i + 1), load_count, i + 1);
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      chk("done_pulse", load_done, 1);
      chk("done_busy", load_busy, 0);
      chk("done_ready", load_ready, 0);
      chk("done_count", load_count, 3);
      tick();
      chk("done_clear", load_done, 0);
      chk("idle_count", load_count, 3);
      drain();

      // Fetch timing: address driven after edge N, data valid before N+1
      @(posedge clk);
      #1 cpu_addr = 16'h0100;
      #1 chk("fetch", cpu_rdata, 16'h7800);

      // Wrap test
      load_start = 1'b1;
      load_base  = 12'hFFF;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data  = 16'h1111;
      push(12'hFFF, 16'h1111);
      tick();
      load_data  = 16'h2222;
      load_last  = 1'b1;
      push(12'h000, 16'h2222);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      chk("wrap_done", load_done, 1);
      chk("wrap_count", load_count, 2);
      tick();
      drain();

      // Collision test: loader and CPU both hit 0x020 in one cycle
      load_start = 1'b1;
      load_base  = 12'h01E;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data  = 16'h0E1E;
      push(12'h01E, 16'h0E1E);
      tick();
      load_data  = 16'h0F1F;
      push(12'h01F, 16'h0F1F);
      tick();
      load_data  = 16'hABCD;
      load_last  = 1'b1;
      cpu_addr   = 16'h0020;
      cpu_wdata  = 16'h1234;
      cpu_we_n   = 1'b0;
      push(12'h020, 16'hABCD);
      tick();
      cpu_we_n   = 1'b1;
      load_valid = 1'b0;
      load_last  = 1'b0;
      chk("coll_wperr", wp_err, 0);
      tick();
      drain();

      // CPU write, read-during-write, upper address bits ignored
      cpu_addr  = 16'h0200;
      cpu_wdata = 16'h1000;
      cpu_we_n  = 1'b0;
      tick();
      cpu_we_n  = 1'b1;
      chk("cpu_wr", cpu_rdata, 16'h1000);
      cpu_addr  = 16'hF200;
      cpu_wdata = 16'h0BEE;
      cpu_we_n  = 1'b0;
      #1 chk("rdw_old", cpu_rdata, 16'h1000);
      tick();
      cpu_we_n  = 1'b1;
      chk("rdw_new", cpu_rdata, 16'h0BEE);
      push(12'h200, 16'h0BEE);
      drain();

      // Reset test: reset after 2 of 5 words
      load_start = 1'b1;
      load_base  = 12'h300;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1;
         load_data  = 16'h3000 + 16'(i);
         push(12'h300 + 12'(i), 16'h3000 + 16'(i));
         tick();
      end
      cpu_addr = 16'h0100;
      #1 chk("rd_in_load", cpu_rdata, 16'h7800);
      load_data = 16'h3002;
      #1 reset_n = 1'b0;
      #1;
      chk("mrst_busy", load_busy, 0);
      chk("mrst_ready", load_ready, 0);
      chk("mrst_count", load_count, 0);
      load_valid = 1'b0;
      cpu_addr   = 16'h0300;
      #1 chk("rst_rdata", cpu_rdata, 16'h3000);
      tick();
      reset_n = 1'b1;
      tick();
      drain();
      load_start = 1'b1;
      load_base  = 12'h400;
      tick();
      load_start = 1'b0;
      chk("restart_busy", load_busy, 1);
      load_valid = 1'b1;
      load_data  = 16'h4444;
      load_last  = 1'b1;
      push(12'h400, 16'h4444);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      chk("restart_done", load_done, 1);
      chk("restart_cnt", load_count, 1);
      tick();
      drain();

      // Protection test; the loader seeds 0x005 (loader is never protected)
      load_start = 1'b1;
      load_base  = 12'h005;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data  = 16'h00AA;
      load_last  = 1'b1;
      push(12'h005, 16'h00AA);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      tick();
      drain();
      cpu_addr  = 16'h0005;
      cpu_wdata = 16'h5555;
      cpu_we_n  = 1'b0;
      tick();
      cpu_we_n  = 1'b1;
`ifdef MANO_MEM_WP_EN
      chk("wp_pulse", wp_err, 1);
      prot_exp = 16'h00AA;
`else
      chk("wp_pulse", wp_err, 0);
      prot_exp = 16'h5555;
`endif
      tick();
      chk("wp_clear", wp_err, 0);
      cpu_addr = 16'h0005;
      #1 chk("wp_mem", cpu_rdata, prot_exp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
